if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues word reads to instruction memory over a req/gnt/rvalid handshake and buffers returned {pc, insn} pairs in a small queue. The IF/ID stage drains the queue with a valid/ready handshake. A redirect (branch taken or flush) restarts fetch at a new PC and discards stale data.

Parameters:
ADDR_W, 32, fetch address / PC width
DATA_W, 32, instruction width
DEPTH, 2, queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0013, value driven on out_insn when queue empty

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect  in  1  branch taken / flush; restart fetch
redirect_pc  in  ADDR_W  new fetch PC, sampled when redirect=1
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  word-aligned read address
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  DATA_W  read data
out_valid  out  1  queue head valid
out_pc  out  ADDR_W  PC of head instruction
out_insn  out  DATA_W  head instruction; NOP_INSN when empty
out_ready  in  1  downstream consumes head when out_valid=1

Behaviour:
- Reset is synchronous and active-high on clk. While reset=1: state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, drop=0. Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_insn=NOP_INSN. Instruction memory shares this reset, so no pre-reset rvalid arrives afterwards.
- imem_addr = fetch_pc at all times. fetch_pc[1:0] is always 0; redirect_pc[1:0] is ignored and forced to 0.
- At most one outstanding request. FSM:
  - IDLE: imem_req=0. Go to REQ when count < DEPTH.
  - REQ: imem_req=1. Address is held stable until gnt. On imem_gnt: fetch_pc += 4 (wraps modulo 2^ADDR_W) and go to WAIT_DATA.
  - WAIT_DATA: imem_req=0. On imem_rvalid with drop=0, push {pc_of_req, rdata}. The captured pc_of_req is fetch_pc before the increment. Next state is REQ if count after push/pop < DEPTH, else IDLE. On imem_rvalid with drop=1, push nothing, clear drop and go to REQ.
- Queue:
  - Registered FIFO. out_valid = (count != 0). out_pc/out_insn show the head entry, or 0/NOP_INSN when empty.
  - Pop occurs when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Pushing into a full queue is structurally impossible because a slot is reserved before entering REQ.
- Latency: gnt in cycle N, rvalid in N+1, out_valid=1 in N+2 (empty queue). Peak throughput is one instruction every 2 cycles when gnt and rvalid each arrive immediately.
- Redirect (highest priority, takes effect at the clock edge):
  - Queue is cleared (count=0, pointers=0). out_valid=0 in the next cycle; a pop in the redirect cycle is ignored.
  - fetch_pc <= redirect_pc & ~3.
  - From IDLE or REQ: next state REQ. A request without gnt is abandoned; the memory protocol permits withdrawal.
  - Redirect in the same cycle as imem_gnt in REQ: go to WAIT_DATA with drop=1, and fetch_pc = redirect_pc (no +4).
  - In WAIT_DATA with no rvalid this cycle: drop=1, stay in WAIT_DATA.
  - In WAIT_DATA with rvalid this cycle: data is discarded, drop=0, next state REQ.
- Redirect during reset is ignored; reset wins.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after gnt, out_ready=1 → imem_addr sequence 0,4,8…; out_pc 0,4,8 with matching rdata; out_valid first high 2 cycles after first gnt.
- out_ready=0 with DEPTH=2 → two entries (pc 0, 4) fill; imem_req stays 0 after the second push. Raise out_ready → pc 0 pops, then refetch resumes at addr 8.
- gnt held low for 5 cycles → imem_req=1 with imem_addr=0 stable throughout; no fetch_pc change until gnt.
- redirect with redirect_pc=32'h100 while WAIT_DATA → the pending rvalid (data for pc 4) is dropped; next imem_addr=32'h100; out_pc=32'h100 appears; queue empty in between.
- redirect with redirect_pc=32'h203 same cycle as gnt → the response for the old address is dropped; next request address is 32'h200 (not 32'h204).
- reset asserted mid-WAIT_DATA with the queue holding 1 entry → next cycle out_valid=0, out_insn=32'h13, imem_req=0, imem_addr=0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC, issues one word read at a time to instruction memory
// (req/gnt/rvalid) and buffers returned {pc, insn} pairs in a small FIFO
// that the IF/ID stage drains with a valid/ready handshake. A redirect
// clears the FIFO, restarts fetch at a new PC and discards a pending
// response that belongs to the old path.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   redirect, redirect_pc branch/flush request and new fetch PC
//   imem_req, imem_addr   read request and word-aligned address
//   imem_gnt              memory accepted the request this cycle
//   imem_rvalid/_rdata    read response
//   out_valid/_pc/_insn   queue head (NOP_INSN and pc 0 when empty)
//   out_ready             downstream consumes the head when out_valid=1
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_insn,
    input  logic              out_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'd3);
    localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_next_s;
    logic [ADDR_W-1:0] req_pc_r, req_pc_next_s;
    logic              drop_r, drop_next_s;
    logic              req_r, req_next_s;

    logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
    logic [DATA_W-1:0] mem_insn_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]  count_r, count_after_s;

    logic              push_s, pop_s;
    logic [ADDR_W-1:0] redirect_pc_a_s;

    // The two address LSBs of a redirect target are always forced to zero.
    assign redirect_pc_a_s = redirect_pc & ALIGN_MASK;

    // A redirect squashes both a same-cycle push and a same-cycle pop.
    assign push_s        = (state_r == ST_WAIT) && imem_rvalid && !drop_r && !redirect;
    assign pop_s         = (count_r != CNT_W'(1'b0)) && out_ready && !redirect;
    assign count_after_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

    assign imem_addr = fetch_pc_r;
    assign imem_req  = req_r;

    // FSM and fetch-PC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC_A;
            req_pc_r   <= RESET_PC_A;
            drop_r     <= 1'b0;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_pc_r   <= req_pc_next_s;
            drop_r     <= drop_next_s;
            req_r      <= req_next_s;
        end
    end

    // Next-state logic: one outstanding request, a queue slot is reserved
    // before entering REQ so a push can never hit a full queue.
    always_comb begin
        state_next_s  = state_r;
        drop_next_s   = drop_r;
        req_pc_next_s = req_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    state_next_s = ST_REQ;
                end else if (count_r < DEPTH_C) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_next_s  = ST_WAIT;
                    req_pc_next_s = fetch_pc_r;
                    // Granted on the old path while redirecting: its data is stale.
                    drop_next_s   = redirect;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    drop_next_s = 1'b0;
                    if (redirect || drop_r) begin
                        state_next_s = ST_REQ;
                    end else if (count_after_s < DEPTH_C) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                    if (redirect) begin
                        drop_next_s = 1'b1;
                    end else begin
                        drop_next_s = drop_r;
                    end
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                drop_next_s  = 1'b0;
            end
        endcase

        if (redirect) begin
            fetch_pc_next_s = redirect_pc_a_s;
        end else if ((state_r == ST_REQ) && imem_gnt) begin
            fetch_pc_next_s = fetch_pc_r + ADDR_W'(3'd4);
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
    end

    // Output decode: request flag registered from next state, queue head view.
    always_comb begin
        req_next_s = (state_next_s == ST_REQ);
        if (count_r != CNT_W'(1'b0)) begin
            out_valid = 1'b1;
            out_pc    = mem_pc_r[rd_ptr_r];
            out_insn  = mem_insn_r[rd_ptr_r];
        end else begin
            out_valid = 1'b0;
            out_pc    = ADDR_W'(1'b0);
            out_insn  = NOP_INSN;
        end
    end

    // Queue pointers and occupancy; reset and redirect both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            count_r  <= CNT_W'(1'b0);
            rd_ptr_r <= PTR_W'(1'b0);
            wr_ptr_r <= PTR_W'(1'b0);
        end else begin
            count_r <= count_after_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Queue storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= req_pc_r;
            mem_insn_r[wr_ptr_r] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue. A small instruction-memory
// responder grants whenever gnt_en is set and answers rv_delay cycles
// after the grant with insn = {16'hDEAD, addr[15:0]}.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        out_ready;

    logic        gnt_en;
    int unsigned rv_delay;
    logic        pend_r;
    logic [31:0] paddr_r;
    int unsigned wait_r;

    int errors = 0;
    int checks = 0;

    if_fetch_queue dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {16'hDEAD, a[15:0]};
    endfunction

    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend_r && (wait_r == 0);
    assign imem_rdata  = insn_of(paddr_r);

    // Memory responder: latch address on grant, answer after rv_delay cycles.
    always @(posedge clk) begin
        if (reset) begin
            pend_r  <= 1'b0;
            wait_r  <= 0;
            paddr_r <= 32'h0;
        end else begin
            if (imem_rvalid) pend_r <= 1'b0;
            else if (pend_r && wait_r != 0) wait_r <= wait_r - 1;
            if (imem_req && imem_gnt) begin
                pend_r  <= 1'b1;
                paddr_r <= imem_addr;
                wait_r  <= rv_delay;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        gnt_en = 1'b1; rv_delay = 0; out_ready = rdy;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        gnt_en = 1'b1; rv_delay = 0; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", out_pc); end
        checks++; if (out_insn !== 32'h0000_0013) begin errors++; $display("FAIL reset_insn: got %h want 00000013", out_insn); end
        redirect = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            e = 32'd4 * k;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req%0d: got %0b want 1", k, imem_req); end
            checks++; if (imem_addr !== e) begin errors++; $display("FAIL stream_addr%0d: got %h want %h", k, imem_addr, e); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_gap%0d: got %0b want 0", k, out_valid); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d: got %0b want 1", k, out_valid); end
            checks++; if (out_pc !== e) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", k, out_pc, e); end
            checks++; if (out_insn !== {16'hDEAD, e[15:0]}) begin errors++; $display("FAIL stream_insn%0d: got %h want %h", k, out_insn, {16'hDEAD, e[15:0]}); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        tick(); tick(); tick();
        checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got v=%0b pc=%h want v=1 pc=00000000", out_valid, out_pc); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL bp_addr4: got %h want 00000004", imem_addr); end
        tick(); tick();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr8: got %h want 00000008", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req%0d: got %0b want 0", i, imem_req); end
            tick();
        end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_hold_pc: got %h want 00000000", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL bp_pop_pc: got %h want 00000004", out_pc); end
        checks++; if (out_insn !== 32'hDEAD_0004) begin errors++; $display("FAIL bp_pop_insn: got %h want dead0004", out_insn); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_refetch: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_refull_req: got %0b want 0", imem_req); end
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL bp_refull_pc: got %h want 00000004", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_pc !== 32'h8 || out_insn !== 32'hDEAD_0008) begin errors++; $display("FAIL bp_pc8: got pc=%h insn=%h want 00000008 dead0008", out_pc, out_insn); end
    endtask

    task automatic test_gnt_stall();
        do_reset(1'b1);
        gnt_en = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall%0d: got req=%0b addr=%h want req=1 addr=00000000", i, imem_req, imem_addr); end
            if (i < 4) tick();
        end
        gnt_en = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_gnt: got req=%0b addr=%h want req=0 addr=00000004", imem_req, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL stall_out: got v=%0b pc=%h want v=1 pc=00000000", out_valid, out_pc); end
    endtask

    task automatic test_redirect_wait();
        do_reset(1'b1);
        tick(); tick(); tick();
        rv_delay = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0; rv_delay = 0;
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_addr: got req=%0b addr=%h want req=0 addr=00000100", imem_req, imem_addr); end
        for (int i = 0; i < 10; i++) begin
            if (imem_req === 1'b1) break;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_empty%0d: got %0b want 0", i, out_valid); end
            tick();
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_req_timeout: got %0b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rw_req_addr: got %h want 00000100", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got v=%0b pc=%h want v=0", out_valid, out_pc); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL rw_out: got v=%0b pc=%h want v=1 pc=00000100", out_valid, out_pc); end
        checks++; if (out_insn !== 32'hDEAD_0100) begin errors++; $display("FAIL rw_insn: got %h want dead0100", out_insn); end
    endtask

    task automatic test_redirect_gnt();
        do_reset(1'b1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b0) begin errors++; $display("FAIL rg_addr: got req=%0b addr=%h want req=0 addr=00000200", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rg_req: got req=%0b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rg_dropped: got v=%0b pc=%h want v=0", out_valid, out_pc); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_insn !== 32'hDEAD_0200) begin errors++; $display("FAIL rg_out: got v=%0b pc=%h insn=%h want 1 00000200 dead0200", out_valid, out_pc, out_insn); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        gnt_en = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got req=%0b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        gnt_en = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_insn !== 32'hDEAD_FFFC) begin errors++; $display("FAIL wrap_out: got v=%0b pc=%h insn=%h want 1 fffffffc deadfffc", out_valid, out_pc, out_insn); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %0b want 1", out_valid); end
        rv_delay = 4;
        tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL rm_wait: got req=%0b addr=%h want req=0 addr=00000008", imem_req, imem_addr); end
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %0b want 0", out_valid); end
        checks++; if (out_insn !== 32'h0000_0013) begin errors++; $display("FAIL rm_insn: got %h want 00000013", out_insn); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 00000000", imem_addr); end
        reset = 1'b0; rv_delay = 0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
